// File: rtl/uart_tx_sched_if.sv
// Bundle of the scheduler's request, transmitter and status signals.
// master = system side (requesters plus TX stub), slave = scheduler.
interface uart_tx_sched_if #(
    parameter int DATA_WD = 8
);
    logic [DATA_WD-1:0]   RF_RdData;
    logic                 RF_Valid;
    logic                 RF_Ack;
    logic [2*DATA_WD-1:0] ALU_Out;
    logic                 ALU_Valid;
    logic                 ALU_Ack;
    logic [DATA_WD-1:0]   TX_P_DATA;
    logic                 TX_Data_Valid;
    logic                 TX_Busy;
    logic                 Sched_Busy;

    modport master (
        output RF_RdData, RF_Valid, ALU_Out, ALU_Valid, TX_Busy,
        input  RF_Ack, ALU_Ack, TX_P_DATA, TX_Data_Valid, Sched_Busy
    );

    modport slave (
        input  RF_RdData, RF_Valid, ALU_Out, ALU_Valid, TX_Busy,
        output RF_Ack, ALU_Ack, TX_P_DATA, TX_Data_Valid, Sched_Busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: shares one UART TX between the RF path
// (one byte per word) and the ALU path (two bytes per word, LSB first).
module uart_tx_sched #(
    parameter int DATA_WD   = 8,
    parameter int BUSY_WAIT = 4
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_sched_if.slave bus,
    output logic [1:0]     o_dbg_state
);
    // Handshake: a source raises Valid with stable data and holds both until
    // its Ack, a single-cycle pulse issued the cycle after the grant; the word
    // is latched at the grant. TX_Data_Valid is a one-cycle load strobe, and
    // TX_Busy high then low marks the transmitter taking and finishing a frame.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(BUSY_WAIT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [2*DATA_WD-1:0] r_hold;
    logic [1:0]           r_byte_cnt;
    logic                 r_byte_sel;
    logic                 r_last_alu;
    logic                 r_rf_ack;
    logic                 r_alu_ack;
    logic [3:0]           r_wait;
    logic [3:0]           w_wait_inc;
    logic                 w_grant_rf;
    logic                 w_grant_alu;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // On a tie the source that was not granted last wins.
    always_comb begin
        w_next_state = r_state;
        w_grant_rf   = 1'b0;
        w_grant_alu  = 1'b0;
        w_wait_inc   = r_wait + 4'd1;
        case (r_state)
            ST_IDLE: begin
                if (bus.RF_Valid && (!bus.ALU_Valid || r_last_alu)) begin
                    w_grant_rf   = 1'b1;
                    w_next_state = ST_LOAD;
                end else if (bus.ALU_Valid) begin
                    w_grant_alu  = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: w_next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.TX_Busy)                w_next_state = ST_WAIT_DONE;
                else if (w_wait_inc == WAIT_LAST) w_next_state = ST_LOAD;
            end
            ST_WAIT_DONE: begin
                if (!bus.TX_Busy) w_next_state = (r_byte_cnt > 2'd1) ? ST_LOAD : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold     <= '0;
            r_byte_cnt <= 2'd0;
            r_byte_sel <= 1'b0;
            r_last_alu <= 1'b1;
            r_rf_ack   <= 1'b0;
            r_alu_ack  <= 1'b0;
            r_wait     <= 4'd0;
        end else begin
            r_rf_ack  <= w_grant_rf;
            r_alu_ack <= w_grant_alu;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rf) begin
                        r_hold     <= {{DATA_WD{1'b0}}, bus.RF_RdData};
                        r_byte_cnt <= 2'd1;
                        r_byte_sel <= 1'b0;
                        r_last_alu <= 1'b0;
                    end else if (w_grant_alu) begin
                        r_hold     <= bus.ALU_Out;
                        r_byte_cnt <= 2'd2;
                        r_byte_sel <= 1'b0;
                        r_last_alu <= 1'b1;
                    end
                end
                ST_LOAD:      r_wait <= 4'd0;
                ST_WAIT_BUSY: if (!bus.TX_Busy) r_wait <= w_wait_inc;
                ST_WAIT_DONE: begin
                    if (!bus.TX_Busy) begin
                        r_byte_cnt <= r_byte_cnt - 2'd1;
                        if (r_byte_cnt > 2'd1) r_byte_sel <= 1'b1;
                    end
                end
                default: r_wait <= 4'd0;
            endcase
        end
    end

    // The byte select only moves at grant or between ALU bytes, so the data
    // output keeps showing the last byte sent while the block is idle.
    always_comb begin
        bus.TX_Data_Valid = (r_state == ST_LOAD);
        bus.TX_P_DATA     = r_byte_sel ? r_hold[2*DATA_WD-1:DATA_WD] : r_hold[DATA_WD-1:0];
        bus.RF_Ack        = r_rf_ack;
        bus.ALU_Ack       = r_alu_ack;
        bus.Sched_Busy    = (r_state != ST_IDLE);
        o_dbg_state       = r_state;
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios followed by random
// traffic, with a TX stub, an arbitration model and a byte scoreboard.
module tb_uart_tx_sched;
    localparam int DATA_WD   = 8;
    localparam int BUSY_WAIT = 4;
    localparam int W         = DATA_WD + 1;  // {second-ALU-byte tag, byte}

    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;

    uart_tx_sched_if #(.DATA_WD(DATA_WD)) bus ();

    uart_tx_sched #(.DATA_WD(DATA_WD), .BUSY_WAIT(BUSY_WAIT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    int             cyc = 0;
    int             busy_cnt = 0;
    int             drop_next = 0;
    bit             rand_drops = 1'b0;
    bit             last_grant_alu = 1'b1;
    int             n_req = 0;
    int             n_ack = 0;

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- TX stub: busy for a random frame length ----------------
    initial begin
        bus.TX_Busy = 1'b0;
        forever begin
            @(posedge CLK);
            if (!RST) begin
                busy_cnt    = 0;
                bus.TX_Busy = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    #1;
                    bus.TX_Busy = 1'b0;
                    drop_next = (rand_drops && $urandom_range(0, 5) == 0) ? 1 : 0;
                end
            end else if (bus.TX_Data_Valid) begin
                if (drop_next > 0) drop_next--;
                else begin
                    #1;
                    bus.TX_Busy = 1'b1;
                    busy_cnt = $urandom_range(2, 12);
                end
            end
        end
    end

    // ---------------- grant model: predicts winner, pushes expected bytes ----------------
    initial begin
        bit           s_rf, s_alu, s_sb, s_rst, exp_alu;
        logic [7:0]   s_rf_d;
        logic [15:0]  s_alu_d;
        forever begin
            @(posedge CLK);
            s_rf    = bus.RF_Valid;
            s_alu   = bus.ALU_Valid;
            s_rf_d  = bus.RF_RdData;
            s_alu_d = bus.ALU_Out;
            s_sb    = bus.Sched_Busy;
            s_rst   = RST;
            #1;
            if (!s_rst || !RST) continue;
            if (!s_sb && (s_rf || s_alu)) begin
                exp_alu = (s_rf && s_alu) ? !last_grant_alu : s_alu;
                check("rf_ack_on_grant", 32'(bus.RF_Ack), 32'(!exp_alu));
                check("alu_ack_on_grant", 32'(bus.ALU_Ack), 32'(exp_alu));
                check("ack_with_strobe", 32'(bus.TX_Data_Valid), 32'd1);
                last_grant_alu = exp_alu;
                n_ack++;
                if (exp_alu) begin
                    exp_q.push_back({1'b0, s_alu_d[7:0]});
                    exp_q.push_back({1'b1, s_alu_d[15:8]});
                end else begin
                    exp_q.push_back({1'b0, s_rf_d});
                end
            end else begin
                check("no_ack", 32'({bus.RF_Ack, bus.ALU_Ack}), 32'd0);
            end
        end
    end

    // ---------------- monitor: compares each strobe against the scoreboard ----------------
    initial begin
        int           last_busy_cyc, last_strobe_cyc;
        bit           prev_sb, prev_dropped;
        logic [W-1:0] e;
        last_busy_cyc = 0; last_strobe_cyc = 0; prev_sb = 1'b0; prev_dropped = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev_sb = 1'b0;
                prev_dropped = 1'b0;
                continue;
            end
            if (bus.TX_Data_Valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got byte %0h, expected no strobe (cycle %0d)",
                             bus.TX_P_DATA, cyc);
                end else begin
                    e = exp_q[0];
                    check("tx_byte", 32'(bus.TX_P_DATA), 32'(e[7:0]));
                    if (prev_dropped) check("retry_spacing", 32'(cyc - last_strobe_cyc), 32'(BUSY_WAIT));
                    else if (e[8])    check("alu_byte_gap", 32'(cyc - last_busy_cyc), 32'd2);
                    if (drop_next > 0) prev_dropped = 1'b1;
                    else begin
                        prev_dropped = 1'b0;
                        void'(exp_q.pop_front());
                    end
                end
                last_strobe_cyc = cyc;
            end
            if (prev_sb && !bus.Sched_Busy) check("sched_busy_drop", 32'(cyc - last_busy_cyc), 32'd2);
            if (bus.TX_Busy) last_busy_cyc = cyc;
            prev_sb = bus.Sched_Busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rf_send(input logic [7:0] d);
        @(negedge CLK);
        bus.RF_RdData = d;
        bus.RF_Valid  = 1'b1;
        n_req++;
        for (int t = 0; t < 4000; t++) begin
            @(negedge CLK);
            if (bus.RF_Ack) break;
        end
        check("rf_ack_seen", 32'(bus.RF_Ack), 32'd1);
        bus.RF_Valid  = 1'b0;
        bus.RF_RdData = 8'($urandom);
    endtask

    task automatic alu_send(input logic [15:0] d);
        @(negedge CLK);
        bus.ALU_Out   = d;
        bus.ALU_Valid = 1'b1;
        n_req++;
        for (int t = 0; t < 4000; t++) begin
            @(negedge CLK);
            if (bus.ALU_Ack) break;
        end
        check("alu_ack_seen", 32'(bus.ALU_Ack), 32'd1);
        bus.ALU_Valid = 1'b0;
        bus.ALU_Out   = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(negedge CLK);
            if (!bus.Sched_Busy && !bus.TX_Busy && exp_q.size() == 0) break;
        end
        check("idle_reached", 32'(bus.Sched_Busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RST = 1'b0;
        bus.RF_Valid = 1'b0; bus.ALU_Valid = 1'b0;
        bus.RF_RdData = '0;  bus.ALU_Out = '0;
        repeat (3) @(negedge CLK);
        check("rst_data_valid", 32'(bus.TX_Data_Valid), 32'd0);
        check("rst_rf_ack", 32'(bus.RF_Ack), 32'd0);
        check("rst_alu_ack", 32'(bus.ALU_Ack), 32'd0);
        check("rst_sched_busy", 32'(bus.Sched_Busy), 32'd0);
        check("rst_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        RST = 1'b1;

        rf_send(8'hA3);
        wait_idle();
        check("p_data_holds", 32'(bus.TX_P_DATA), 32'hA3);
        alu_send(16'hB4D2);
        wait_idle();

        // tie after reset, then both requesting again
        fork rf_send(8'h11); alu_send(16'h2233); join
        fork rf_send(8'h11); alu_send(16'h2233); join
        wait_idle();

        // transmitter ignores the first strobe
        drop_next = 1;
        rf_send(8'h5A);
        wait_idle();

        // reset while the first ALU byte is in flight
        alu_send(16'hC0DE);
        for (int t = 0; t < 100; t++) begin
            if (dbg_state == 2'd3) break;
            @(negedge CLK);
        end
        check("reach_wait_done", 32'(dbg_state), 32'd3);
        #2 RST = 1'b0;
        #1;
        check("midrst_data_valid", 32'(bus.TX_Data_Valid), 32'd0);
        check("midrst_rf_ack", 32'(bus.RF_Ack), 32'd0);
        check("midrst_alu_ack", 32'(bus.ALU_Ack), 32'd0);
        check("midrst_sched_busy", 32'(bus.Sched_Busy), 32'd0);
        check("midrst_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        last_grant_alu = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);

        // RF request raised during an ALU transfer
        fork
            alu_send(16'($urandom));
            begin
                repeat (3) @(negedge CLK);
                rf_send(8'($urandom));
            end
        join
        wait_idle();

        // random traffic with occasional ignored strobes
        rand_drops = 1'b1;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 20)) @(negedge CLK);
                rf_send(8'($urandom));
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 20)) @(negedge CLK);
                alu_send(16'($urandom));
            end
        join
        wait_idle();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("all_acked", 32'(n_ack), 32'(n_req));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler in front of the UART transmitter. Two requesters share the single serial TX path: the register-file read path, which sends 8-bit words, and the ALU result path, which sends 16-bit words as two frames, LSB first. The block arbitrates round-robin, latches the granted word, and pulses the transmitter's data-valid for each byte. It tracks the transmitter's busy flag so that a new byte is only loaded after the previous frame has completed. It sits between the system controller and the UART_TX instance in the UART clock domain.

## Interface

Parameters:
- DATA_WD, 8, byte width presented to the transmitter.
- BUSY_WAIT, 4, cycles to wait for busy to rise after a data-valid pulse before re-pulsing. Legal range is 2..15.

Ports:
- CLK  in  1  UART TX clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RF_RdData  in  DATA_WD  register-file word to send.
- RF_Valid  in  1  RF request. Held high, with data stable, until RF_Ack.
- RF_Ack  out  1  one-cycle pulse: RF word latched, request may drop.
- ALU_Out  in  2*DATA_WD  ALU result to send.
- ALU_Valid  in  1  ALU request. Held high, with data stable, until ALU_Ack.
- ALU_Ack  out  1  one-cycle pulse: ALU word latched.
- TX_P_DATA  out  DATA_WD  byte to the transmitter's P_DATA.
- TX_Data_Valid  out  1  one-cycle load strobe to the transmitter's Data_Valid.
- TX_Busy  in  1  transmitter busy flag.
- Sched_Busy  out  1  high whenever the state is not IDLE.

## Operation

States and transitions:
- **IDLE**
  - If any Valid is high: grant per round-robin, latch the word into a 16-bit holding register, set the byte count (RF=1, ALU=2), and go to LOAD.
  - The Ack for the granted source is registered, so it is high during the first LOAD cycle.
- **LOAD**
  - TX_P_DATA = current byte: holding[7:0] for byte 0, holding[15:8] for byte 1.
  - TX_Data_Valid = 1 for exactly this cycle.
  - Clear the wait counter and go to WAIT_BUSY.
- **WAIT_BUSY**
  - If TX_Busy = 1, go to WAIT_DONE.
  - Otherwise increment the wait counter. When it reaches BUSY_WAIT-1 without busy rising, return to LOAD and re-pulse the same byte. There is no limit on retries.
- **WAIT_DONE**
  - When TX_Busy = 0, decrement the byte count.
  - If a byte remains, go to LOAD with byte 1. Otherwise go to IDLE.

Arbitration:
- A last-grant flag is kept; on a tie, the source not granted last wins.
- After reset the flag is "ALU", so RF wins the first tie.
- A single requester is always granted.
- Requests arriving while the state is not IDLE wait. No request is ever dropped.

Data handling:
- The holding register is captured only on grant. Source data changes after the Ack are ignored.
- For RF grants, holding[15:8] = 0 and is never sent.
- TX_P_DATA holds its last value outside LOAD.
- TX_Data_Valid is 0 outside LOAD.

## Timing

Reset:
- RST low clears the state to IDLE.
- Clears TX_Data_Valid, RF_Ack, ALU_Ack, Sched_Busy, TX_P_DATA (=0), the counters and the holding register.
- Sets last-grant to ALU.
- Reset mid-frame abandons the word; no Ack is re-issued.

Latency and pacing:
- A Valid sampled high in IDLE at edge n gives Ack and TX_Data_Valid high together in cycle n+1.
- Sched_Busy is high from cycle n+1.
- Busy falling, sampled at edge m in WAIT_DONE:
  - With a byte remaining, the next TX_Data_Valid is in cycle m+1. The gap between ALU bytes is one cycle.
  - With none remaining, Sched_Busy = 0 in cycle m+1. A new grant can occur at edge m+1, with Data_Valid in cycle m+2.
- Acks are exactly one cycle wide, with only one Ack per grant.

Boundary conditions:
- **Busy already high at LOAD:** WAIT_BUSY exits on the first sampled busy.
- **Busy pulse shorter than one cycle:** not supported. Busy must be at least one cycle wide.
- **Both Valid high continuously:** grants alternate RF, ALU, RF, ...

## Test plan

1. **Single RF request.** Reset, then RF_Valid=1 with RF_RdData=8'hA3. Required: RF_Ack and TX_Data_Valid in the same cycle, with TX_P_DATA=8'hA3. A real UART_TX serialises frame 0,A3 LSB-first,1. Sched_Busy drops one cycle after busy falls.
2. **Single ALU request.** ALU_Out=16'hB4D2 with parity enabled and even. Required: frames 8'hD2 then 8'hB4. Exactly two Data_Valid pulses, separated by a one-cycle gap after busy falls. One ALU_Ack.
3. **Tie after reset.** Both Valid high, RF=8'h11 and ALU=16'h2233. Required byte order: 11, 33, 22. Keeping both held (with the same data) then yields ALU, then RF alternation.
4. **Busy timeout.** Use a stub that holds busy low for the first strobe. Required: TX_Data_Valid is re-pulsed after BUSY_WAIT=4 cycles with the same byte. Proceeds normally once busy rises; no extra Ack.
5. **Reset mid-frame.** Assert RST during WAIT_DONE of ALU byte 0 (16'hC0DE). Required: all outputs are 0 immediately and the state is IDLE. Byte 8'hC0 is never strobed.
6. **Request while busy.** RF_Valid rises during an ALU transfer. Required: no RF_Ack until Sched_Busy falls, then grant on the next edge.
